sck_sda_receiver: RTL and testbench
===================================

// Module: sck_sda_receiver
// PURPOSE
//  Receive end of the two-wire sck/sda link driven by the button-triggered `control` transmitter.
//  Conditions the raw lines, then detects START and STOP.
//  Shifts 8-bit MSB-first bytes plus one ACK slot.
//  Presents each byte on a one-cycle strobe to on-board logic; for loopback on the kit and for sigrok cross-checks.
// PARAMETERS
//  SYNC_STAGES   2      synchroniser flops per line (>=2)
//  FILTER_LEN    3      clk cycles a synchronised level must hold before it is accepted (1..15)
//  IDLE_TIMEOUT  27000  clk cycles with no accepted sck edge inside a frame before abort (1 ms @ 27 MHz)
// PORTS
//  clk          in   1  27 MHz system clock
//  rst_n        in   1  asynchronous active-low reset
//  sck          in   1  raw serial clock from transmitter
//  sda          in   1  raw serial data (open-drain line, read side)
//  sda_oe       out  1  1 = pull sda low (ACK drive); 0 = release
//  byte_data    out  8  last received byte, held until next byte_valid
//  byte_valid   out  1  one-cycle strobe, byte_data valid
//  byte_ack     out  1  level seen in ACK slot for the byte just strobed (0 = ACK)
//  frame_start  out  1  one-cycle strobe on accepted START
//  frame_stop   out  1  one-cycle strobe on accepted STOP
//  rx_error     out  1  one-cycle strobe on aborted byte or timeout
//  busy         out  1  high from START until STOP/abort
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, byte_data=8'h00, state IDLE, filters preset to 1 (lines idle high).
//  Conditioning: sync -> filter; accepted levels sck_f/sda_f; edges from sck_f/sda_f vs previous; total latency SYNC_STAGES+FILTER_LEN+1 clk.
//  START = sda_f falls while sck_f=1; STOP = sda_f rises while sck_f=1; valid in any state.
//  States:
//   IDLE  : wait START -> DATA, bit_cnt=0, frame_start=1, busy=1.
//   DATA  : on sck_f rise shift sda_f into shreg (MSB first), bit_cnt++; after 8th rise -> ACK.
//   ACK   : on sck_f rise sample ack bit; next clk byte_valid=1, byte_data=shreg, byte_ack=sample; -> DATA, bit_cnt=0.
//  STOP in DATA with bit_cnt==0: frame_stop=1, busy=0 -> IDLE (clean end).
//  STOP in DATA with bit_cnt!=0, or in ACK: rx_error=1 and frame_stop=1, partial byte discarded -> IDLE.
//  START while busy (repeated start): bit_cnt!=0 -> rx_error=1; always frame_start=1, restart DATA at bit_cnt=0.
//  Timeout counter clears on every accepted sck edge and on START; reaching IDLE_TIMEOUT while busy -> rx_error=1, -> IDLE.
//  Timeout counter does not run in IDLE.
//  sck_f and sda_f changing in the same clk: START/STOP test uses the previous sck_f and takes priority over data shift.
//  byte_valid and frame_stop may assert together only in the same clk as error; never two byte_valid within 9 sck rises.
//  Reset mid-frame: immediate return to IDLE; no strobe generated.
// CONFIGURATION
//  `ACK_DRIVE_EN defined: sda_oe=1 from the first sck_f fall after bit 8 until the next sck_f fall (ACK slot).
//   With `ACK_DRIVE_EN, byte_ack reports the sampled line (normally 0).
//   sda_oe=0 on reset, abort and STOP.
//  `ACK_DRIVE_EN not defined: sda_oe tied 0; the block is a passive listener and byte_ack reports the transmitter's level.
// STRUCTURE
//  Shared include sck_sda_defs.vh: state encodings (ST_IDLE=2'd0, ST_DATA=2'd1, ST_ACK=2'd2), BITS_PER_BYTE=8, CLK_HZ=27_000_000.
//  The transmitter side uses the same include.
//  Sub-module line_sync_filter (params SYNC_STAGES, FILTER_LEN; ports clk, rst_n, din, dout), instantiated for sck and sda.
//  Top holds edge detect, FSM, shift register, bit counter and timeout counter.
// TESTING
//  Bench drives sck/sda at 100 kHz bit rate from a task.
//  It checks strobes against a scoreboard and runs with and without `ACK_DRIVE_EN.
//  1 START, 0xA5, ACK=0, STOP -> frame_start, byte_valid with byte_data=8'hA5 and byte_ack=0, frame_stop, rx_error never asserted.
//  2 START, 0x00, 0xFF, 0x3C, STOP -> three byte_valid in order 00/FF/3C, busy high throughout, one frame_stop.
//  3 START, 5 bits, STOP -> rx_error=1 and frame_stop=1 in same clk, no byte_valid, busy=0.
//  4 START, 0x81, ACK, repeated START, 0x7E, STOP -> bytes 81 then 7E, two frame_start, no rx_error.
//  5 START, 3 bits, sck held high 1.1 ms -> rx_error at IDLE_TIMEOUT clk after last edge, state IDLE.
//  6 1-clk glitches on sck/sda with FILTER_LEN=3 -> no strobes.
//  7 (ACK_DRIVE_EN) sda_oe high exactly over the 9th sck period only.
//  8 rst_n pulsed low mid-byte -> outputs 0 asynchronously; the next clean frame decodes correctly.

Source files
------------

// File: rtl/sck_sda_receiver_pkg.sv
// ---------------------------------------------------------------------------
// sck_sda_receiver_pkg
// Shared definitions for the two-wire sck/sda link, used by both the
// transmitter and the receiver side.
//   state_t        FSM state encodings (IDLE / DATA / ACK)
//   BITS_PER_BYTE  data bits per byte before the ACK slot
//   CLK_HZ         system clock frequency, used for timing defaults
//   shift_in()     MSB-first shift helper
// ---------------------------------------------------------------------------
package sck_sda_receiver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam int BITS_PER_BYTE = 8;
   localparam int CLK_HZ        = 27_000_000;

   // Shift one bit in at the LSB end so the first bit received ends up as MSB.
   function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
      return {sr[6:0], b};
   endfunction

endpackage

// File: rtl/sck_sda_receiver_line_sync_filter.sv
// ---------------------------------------------------------------------------
// line_sync_filter
// Synchronises one raw asynchronous line into clk and rejects short glitches:
// the synchronised level must differ from the accepted level for FILTER_LEN
// consecutive clk cycles before it becomes the new accepted level.
// Both the synchroniser and the accepted level reset to 1 (idle-high line).
// Parameters:
//   SYNC_STAGES  synchroniser depth (>= 2)
//   FILTER_LEN   cycles a new level must be held (1..15)
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   din    in  raw line
//   dout   out accepted (synchronised, filtered) level
// ---------------------------------------------------------------------------
module line_sync_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [3:0]             cnt_reg;
   logic                   dout_reg;
   logic                   sync_out;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) sync_reg[gi] <= 1'b1;
               else        sync_reg[gi] <= din;
            end
         end else begin : g_rest
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) sync_reg[gi] <= 1'b1;
               else        sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign sync_out = sync_reg[SYNC_STAGES-1];

   // cnt_reg counts how long the synchronised level has disagreed with the
   // accepted level; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg  <= 4'd0;
         dout_reg <= 1'b1;
      end else if (sync_out == dout_reg) begin
         cnt_reg <= 4'd0;
      end else if (cnt_reg == CNT_LAST) begin
         cnt_reg  <= 4'd0;
         dout_reg <= sync_out;
      end else begin
         cnt_reg <= cnt_reg + 4'd1;
      end
   end

   assign dout = dout_reg;

endmodule

// File: rtl/sck_sda_receiver.sv
// ---------------------------------------------------------------------------
// sck_sda_receiver
// Receive end of the two-wire sck/sda link. Conditions both lines, detects
// START/STOP, shifts MSB-first bytes followed by one ACK slot and presents
// each byte with a one-cycle strobe.
// Optional feature macro: ACK_DRIVE_EN -- when defined the receiver pulls sda
// low over the ACK slot; otherwise sda_oe is held 0 (passive listener).
// Parameters:
//   SYNC_STAGES   synchroniser flops per line
//   FILTER_LEN    glitch filter length in clk cycles
//   IDLE_TIMEOUT  clk cycles without an sck edge inside a frame before abort
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sck, sda      raw line inputs
//   sda_oe        1 = pull sda low (ACK drive)
//   byte_data     last received byte
//   byte_valid    one-cycle strobe, byte_data/byte_ack valid
//   byte_ack      level seen in the ACK slot (0 = ACK)
//   frame_start   one-cycle strobe on START
//   frame_stop    one-cycle strobe on STOP
//   rx_error      one-cycle strobe on aborted byte or timeout
//   busy          high from START until STOP/abort
// ---------------------------------------------------------------------------
module sck_sda_receiver
   import sck_sda_receiver_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int FILTER_LEN   = 3,
   parameter int IDLE_TIMEOUT = CLK_HZ / 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sck,
   input  logic       sda,
   output logic       sda_oe,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       byte_ack,
   output logic       frame_start,
   output logic       frame_stop,
   output logic       rx_error,
   output logic       busy
);

`ifdef ACK_DRIVE_EN
   localparam bit ACK_DRIVE = 1'b1;
`else
   localparam bit ACK_DRIVE = 1'b0;
`endif

   localparam int             TO_W      = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);
   localparam logic [3:0]     LAST_BIT  = 4'(BITS_PER_BYTE - 1);
   localparam logic [3:0]     FULL_CNT  = 4'(BITS_PER_BYTE);

   // ---------------- line conditioning ----------------
   logic sck_f, sda_f;
   logic sck_p_reg, sda_p_reg;

   line_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sck_filt (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sck),
      .dout (sck_f)
   );

   line_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sda),
      .dout (sda_f)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_p_reg <= 1'b1;
         sda_p_reg <= 1'b1;
      end else begin
         sck_p_reg <= sck_f;
         sda_p_reg <= sda_f;
      end
   end

   logic sck_rise, sck_fall, start_det, stop_det;

   assign sck_rise  =  sck_f & ~sck_p_reg;
   assign sck_fall  = ~sck_f &  sck_p_reg;
   // The previous sck level qualifies START/STOP, so an sda change landing in
   // the same cycle as an sck change is still judged against a high clock.
   assign start_det =  sda_p_reg & ~sda_f & sck_p_reg;
   assign stop_det  = ~sda_p_reg &  sda_f & sck_p_reg;

   // ---------------- FSM and datapath ----------------
   state_t          state_reg,       state_next;
   logic [3:0]      bit_cnt_reg,     bit_cnt_next;
   logic [7:0]      shreg_reg,       shreg_next;
   logic            bit_smp_reg,     bit_smp_next;
   logic            bit_open_reg,    bit_open_next;
   logic [TO_W-1:0] to_cnt_reg,      to_cnt_next;
   logic [7:0]      byte_data_reg,   byte_data_next;
   logic            byte_valid_reg,  byte_valid_next;
   logic            byte_ack_reg,    byte_ack_next;
   logic            frame_start_reg, frame_start_next;
   logic            frame_stop_reg,  frame_stop_next;
   logic            rx_error_reg,    rx_error_next;
   logic            busy_reg,        busy_next;
   logic            sda_oe_reg,      sda_oe_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         bit_cnt_reg     <= 4'd0;
         shreg_reg       <= 8'h00;
         bit_smp_reg     <= 1'b0;
         bit_open_reg    <= 1'b0;
         to_cnt_reg      <= '0;
         byte_data_reg   <= 8'h00;
         byte_valid_reg  <= 1'b0;
         byte_ack_reg    <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_stop_reg  <= 1'b0;
         rx_error_reg    <= 1'b0;
         busy_reg        <= 1'b0;
         sda_oe_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         bit_cnt_reg     <= bit_cnt_next;
         shreg_reg       <= shreg_next;
         bit_smp_reg     <= bit_smp_next;
         bit_open_reg    <= bit_open_next;
         to_cnt_reg      <= to_cnt_next;
         byte_data_reg   <= byte_data_next;
         byte_valid_reg  <= byte_valid_next;
         byte_ack_reg    <= byte_ack_next;
         frame_start_reg <= frame_start_next;
         frame_stop_reg  <= frame_stop_next;
         rx_error_reg    <= rx_error_next;
         busy_reg        <= busy_next;
         sda_oe_reg      <= sda_oe_next;
      end
   end

   // A data bit is sampled on the sck rise but only counted once its high
   // phase ends with an sck fall. The rise that precedes a STOP or repeated
   // START therefore does not count as a bit, which is what lets a frame end
   // cleanly with bit_cnt == 0.
   always_comb begin
      state_next       = state_reg;
      bit_cnt_next     = bit_cnt_reg;
      shreg_next       = shreg_reg;
      bit_smp_next     = bit_smp_reg;
      bit_open_next    = bit_open_reg;
      to_cnt_next      = (state_reg == ST_IDLE) ? '0 : to_cnt_reg + TO_W'(1);
      byte_data_next   = byte_data_reg;
      byte_valid_next  = 1'b0;
      byte_ack_next    = byte_ack_reg;
      frame_start_next = 1'b0;
      frame_stop_next  = 1'b0;
      rx_error_next    = 1'b0;
      busy_next        = busy_reg;
      sda_oe_next      = sda_oe_reg;

      if (sck_rise || sck_fall) begin
         to_cnt_next = '0;
      end

      if (start_det) begin
         // Repeated START in the middle of a byte loses that byte.
         rx_error_next    = busy_reg && (bit_cnt_reg != 4'd0);
         frame_start_next = 1'b1;
         busy_next        = 1'b1;
         state_next       = ST_DATA;
         bit_cnt_next     = 4'd0;
         bit_open_next    = 1'b0;
         to_cnt_next      = '0;
         sda_oe_next      = 1'b0;
      end else if (stop_det) begin
         if (state_reg != ST_IDLE) begin
            frame_stop_next = 1'b1;
            rx_error_next   = (state_reg == ST_ACK) || (bit_cnt_reg != 4'd0);
            busy_next       = 1'b0;
            state_next      = ST_IDLE;
            bit_cnt_next    = 4'd0;
            bit_open_next   = 1'b0;
            sda_oe_next     = 1'b0;
         end
      end else if ((state_reg != ST_IDLE) && !(sck_rise || sck_fall) &&
                   (to_cnt_reg == TO_LAST)) begin
         rx_error_next = 1'b1;
         busy_next     = 1'b0;
         state_next    = ST_IDLE;
         bit_cnt_next  = 4'd0;
         bit_open_next = 1'b0;
         sda_oe_next   = 1'b0;
      end else begin
         case (state_reg)
            ST_DATA: begin
               if (sck_rise) begin
                  bit_smp_next  = sda_f;
                  bit_open_next = 1'b1;
               end else if (sck_fall) begin
                  // Any fall in DATA ends a previous ACK slot drive.
                  sda_oe_next = 1'b0;
                  if (bit_open_reg) begin
                     shreg_next    = shift_in(shreg_reg, bit_smp_reg);
                     bit_open_next = 1'b0;
                     if (bit_cnt_reg == LAST_BIT) begin
                        // Fall after bit 8 opens the ACK slot.
                        bit_cnt_next = FULL_CNT;
                        state_next   = ST_ACK;
                        sda_oe_next  = ACK_DRIVE;
                     end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                     end
                  end
               end
            end
            ST_ACK: begin
               if (sck_rise) begin
                  byte_valid_next = 1'b1;
                  byte_data_next  = shreg_reg;
                  byte_ack_next   = sda_f;
                  state_next      = ST_DATA;
                  bit_cnt_next    = 4'd0;
                  bit_open_next   = 1'b0;
               end
            end
            default: begin
               // IDLE: only a START leaves this state.
            end
         endcase
      end
   end

   assign sda_oe      = sda_oe_reg;
   assign byte_data   = byte_data_reg;
   assign byte_valid  = byte_valid_reg;
   assign byte_ack    = byte_ack_reg;
   assign frame_start = frame_start_reg;
   assign frame_stop  = frame_stop_reg;
   assign rx_error    = rx_error_reg;
   assign busy        = busy_reg;

endmodule

// File: tb/tb_sck_sda_receiver.sv
`timescale 1ns/100ps
module tb_sck_sda_receiver;

   localparam int SYNC_STAGES  = 2;
   localparam int FILTER_LEN   = 3;
   localparam int IDLE_TIMEOUT = 27000;
   localparam int Q            = 67;   // quarter bit at 100 kHz / 27 MHz

`ifdef ACK_DRIVE_EN
   localparam logic DRV = 1'b1;
`else
   localparam logic DRV = 1'b0;
`endif

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       sck_tx = 1'b1;
   logic       sda_tx = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] byte_data;
   logic       byte_valid, byte_ack, frame_start, frame_stop, rx_error, busy;

   // Open-drain sda: low if either side pulls it low.
   assign sda_line = sda_tx & ~sda_oe;

   always #18.5 clk = ~clk;

   sck_sda_receiver #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sck        (sck_tx),
      .sda        (sda_line),
      .sda_oe     (sda_oe),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ack   (byte_ack),
      .frame_start(frame_start),
      .frame_stop (frame_stop),
      .rx_error   (rx_error),
      .busy       (busy)
   );

   typedef struct packed {
      logic       fs;
      logic       fp;
      logic       err;
      logic       bv;
      logic [7:0] d;
      logic       a;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic push_ev(input logic fs, input logic fp, input logic err,
                          input logic bv, input logic [7:0] d, input logic a);
      ev_t e;
      e.fs = fs; e.fp = fp; e.err = err; e.bv = bv;
      e.d  = bv ? d : 8'h00;
      e.a  = bv ? a : 1'b0;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      ev_t obs, e;
      if (rst_n && (byte_valid || frame_start || frame_stop || rx_error)) begin
         obs.fs = frame_start; obs.fp = frame_stop; obs.err = rx_error; obs.bv = byte_valid;
         obs.d  = byte_valid ? byte_data : 8'h00;
         obs.a  = byte_valid ? byte_ack  : 1'b0;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got fs=%b fp=%b err=%b bv=%b d=%h a=%b, expected none",
                     obs.fs, obs.fp, obs.err, obs.bv, obs.d, obs.a);
         end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
               fails++;
               $display("FAIL event: got fs=%b fp=%b err=%b bv=%b d=%h a=%b, expected fs=%b fp=%b err=%b bv=%b d=%h a=%b",
                        obs.fs, obs.fp, obs.err, obs.bv, obs.d, obs.a,
                        e.fs, e.fp, e.err, e.bv, e.d, e.a);
            end else begin
               $display("ok   event fs=%b fp=%b err=%b bv=%b d=%h a=%b",
                        obs.fs, obs.fp, obs.err, obs.bv, obs.d, obs.a);
            end
         end
      end
   end

   // ---------------- line driver tasks ----------------
   task automatic send_bit(input logic b);
      sda_tx = b;  wait_clk(Q);
      sck_tx = 1'b1; wait_clk(2*Q);
      sck_tx = 1'b0; wait_clk(Q);
   endtask

   task automatic do_start();
      sda_tx = 1'b0; wait_clk(2*Q);
      sck_tx = 1'b0; wait_clk(Q);
   endtask

   task automatic do_rstart();
      sda_tx = 1'b1; wait_clk(Q);
      sck_tx = 1'b1; wait_clk(Q);
      do_start();
   endtask

   task automatic do_stop();
      sda_tx = 1'b0; wait_clk(Q);
      sck_tx = 1'b1; wait_clk(Q);
      sda_tx = 1'b1; wait_clk(2*Q);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ack);
      push_ev(1'b0, 1'b0, 1'b0, 1'b1, d, DRV ? 1'b0 : ack);
      for (int i = 7; i >= 0; i--) begin
         sda_tx = d[i]; wait_clk(Q);
         sck_tx = 1'b1; wait_clk(Q);
         if (i == 7) check("busy_in_byte", 32'(busy), 32'd1);
         if (i == 0) check("oe_bit8", 32'(sda_oe), 32'd0);
         wait_clk(Q);
         sck_tx = 1'b0; wait_clk(Q);
      end
      sda_tx = ack; wait_clk(Q);
      sck_tx = 1'b1; wait_clk(Q);
      check("oe_ack_slot", 32'(sda_oe), 32'(DRV));
      wait_clk(Q);
      sck_tx = 1'b0; wait_clk(Q);
      check("oe_after_ack", 32'(sda_oe), 32'd0);
   endtask

   task automatic drain(input string name);
      wait_clk(20);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cnt;
      wait_clk(5);
      check("reset_outputs", {22'd0, sda_oe, byte_data, byte_valid, byte_ack},           32'd0);
      check("reset_strobes", {28'd0, frame_start, frame_stop, rx_error, busy},          32'd0);
      rst_n = 1'b1;
      wait_clk(10);

      // 1: single byte A5 with ACK
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      do_start();
      send_byte(8'hA5, 1'b0);
      push_ev(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      do_stop();
      drain("t1_queue_empty");
      check("t1_busy_after", 32'(busy), 32'd0);

      // 2: three bytes in one frame
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      do_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h3C, 1'b0);
      push_ev(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      do_stop();
      drain("t2_queue_empty");
      check("t2_busy_after", 32'(busy), 32'd0);

      // 3: STOP after 5 bits -> error and stop together
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      do_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      push_ev(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      do_stop();
      drain("t3_queue_empty");
      check("t3_busy_after", 32'(busy), 32'd0);

      // 4: repeated START between bytes
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      do_start();
      send_byte(8'h81, 1'b0);
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      do_rstart();
      send_byte(8'h7E, 1'b0);
      push_ev(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      do_stop();
      drain("t4_queue_empty");

      // 5: 3 bits then sck held high -> timeout
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      do_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      sda_tx = 1'b1; wait_clk(Q);
      push_ev(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      sck_tx = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!rx_error && cnt < 30000);
      tests++;
      if (cnt < IDLE_TIMEOUT || cnt > IDLE_TIMEOUT + SYNC_STAGES + FILTER_LEN + 2) begin
         fails++;
         $display("FAIL timeout_latency: got %0d clk, expected %0d..%0d", cnt,
                  IDLE_TIMEOUT, IDLE_TIMEOUT + SYNC_STAGES + FILTER_LEN + 2);
      end else begin
         $display("ok   timeout_latency: %0d clk", cnt);
      end
      wait_clk(2);
      check("t5_busy_after", 32'(busy), 32'd0);
      drain("t5_queue_empty");

      // 6: short glitches must be filtered out
      sda_tx = 1'b0; wait_clk(1); sda_tx = 1'b1; wait_clk(8);
      sck_tx = 1'b0; wait_clk(1); sck_tx = 1'b1; wait_clk(8);
      sda_tx = 1'b0; wait_clk(2); sda_tx = 1'b1; wait_clk(8);
      sck_tx = 1'b0; sda_tx = 1'b0; wait_clk(1); sck_tx = 1'b1; sda_tx = 1'b1; wait_clk(8);
      drain("t6_queue_empty");
      check("t6_busy", 32'(busy), 32'd0);

      // 8: asynchronous reset mid-byte, then a clean frame
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      do_start();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      sda_tx = 1'b1; wait_clk(Q);
      sck_tx = 1'b1; wait_clk(10);
      check("t8_busy_before_rst", 32'(busy), 32'd1);
      #5 rst_n = 1'b0;
      #1 check("t8_async_reset", {23'd0, busy, sda_oe, byte_valid, frame_start, frame_stop, rx_error, byte_ack, 2'b00}, 32'd0);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(10);
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      do_start();
      send_byte(8'h5A, 1'b0);
      push_ev(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      do_stop();
      drain("t8_queue_empty");
      check("t8_last_byte", 32'(byte_data), 32'h5A);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
